fft_out_stage_pp: RTL and testbench
===================================

// Module: fft_out_stage_pp
// PURPOSE
//  Double-buffered (ping-pong) FFT output reorder stage. Captures one N-point frame of Re/Im results
//  at scattered write addresses into one bank while the other bank is drained in natural or
//  bit-reversed order over a valid/ready stream. Optional pacing inserts a gap between words for slow sinks (UART).
//  Sits between the last butterfly stage and the serial/stream output.
// PARAMETERS
//  BIT_WIDTH    24  width of Re and Im samples (signed)
//  N            16  points per frame; power of two
//  SIZE          4  log2(N); address width
//  PACE_CYCLES 5207 idle clk cycles after each accepted output word; 0 = back-to-back
// PORTS
//  clk          in   1          single clock, rising edge
//  rst_n        in   1          synchronous reset, active low
//  valid_i      in   1          write strobe for Re_i/Im_i at wr_ptr_i
//  Re_i, Im_i   in   BIT_WIDTH  signed FFT result
//  wr_ptr_i     in   SIZE       write address within current frame (any permutation)
//  bitrev_rd_i  in   1          read order: 0 natural, 1 bit-reversed; sampled at frame start
//  ready_i      in   1          sink accepts output word when valid_o & ready_i
//  Re_o, Im_o   out  BIT_WIDTH  output sample, held stable while valid_o & !ready_i
//  idx_o        out  SIZE       read address of current word
//  valid_o      out  1          output word valid
//  last_o       out  1          current word is last of frame (idx count N-1)
//  done_o       out  1          1-cycle pulse when last word of a frame is accepted
//  overflow_o   out  1          sticky: a frame was dropped because both banks full
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): valid_o,last_o,done_o,overflow_o=0; Re_o,Im_o,idx_o=0; both banks empty;
//   write bank=0, read bank=0; counters 0; reader in R_IDLE. RAM contents not cleared. Mid-frame reset aborts all.
//  Writer: wcnt counts valid_i. Sample with wcnt=0 starts frame: if write bank full -> drop mode for
//   whole frame (N samples discarded, overflow_o<=1). Else writes bank[wbank][wr_ptr_i].
//   On Nth sample: bank full flag set, wbank toggles, wcnt wraps to 0.
//  Reader FSM: R_IDLE -> R_FETCH when rbank full; latch bitrev_rd_i, rcnt=0.
//   R_FETCH: drive RAM read addr = rcnt or bitrev(rcnt); -> R_PRESENT (RAM read latency 1).
//   R_PRESENT: valid_o=1, data registered; hold until ready_i. On accept: if rcnt=N-1 -> release bank
//   (full clear, rbank toggles), done_o pulse, -> R_IDLE; else rcnt++, -> R_GAP (PACE_CYCLES>0) or R_FETCH.
//   R_GAP: count PACE_CYCLES cycles, valid_o=0, -> R_FETCH.
//  Latency: Nth write at cycle t with reader idle -> valid_o=1 at cycle t+3 (flag t+1, fetch t+2, present t+3).
//  Throughput with PACE_CYCLES=0, ready_i=1: one word per 2 cycles.
//  Simultaneous release and writer frame start on same bank: release wins; frame accepted, no drop.
//  Simultaneous write and read of same bank impossible (bank owned by one side); no bypass needed.
//  wr_ptr_i duplicates within a frame: last write wins; no checking.
//  ready_i while valid_o=0 is ignored. bitrev_rd_i changes mid-frame have no effect until next frame.
// STRUCTURE
//  Package fft_out_pkg: reader state enum (R_IDLE,R_FETCH,R_PRESENT,R_GAP), function bitrev(addr,SIZE).
//  Sub-module pp_ram: simple dual-port RAM, 2*N x 2*BIT_WIDTH, addr {bank,ptr}, sync read 1 cycle.
//  Top holds writer counter, full flags, reader FSM, pace counter, output registers.
// TESTING
//  1 N=16, PACE=0, ready=1, write frame at wr_ptr=bitrev(k) with Re=k,Im=-k, bitrev_rd=0 -> Re_o 0..15 natural,
//    last_o on 15, done_o one pulse, first valid_o 3 cycles after last write.
//  2 Same frame, wr_ptr=k, bitrev_rd=1 -> Re_o sequence 0,8,4,12,2,...,15; idx_o matches.
//  3 ready_i held 0 for 10 cycles on word 5 -> Re_o/Im_o/idx_o stable, no word lost or repeated.
//  4 Three frames back-to-back, ready=0 -> frames 1,2 stored, frame 3 dropped, overflow_o=1 sticky;
//    release ready -> frames 1 then 2 output intact.
//  5 PACE_CYCLES=4 -> exactly 4 cycles valid_o=0 between accepted words; 16 words in expected cycle count.
//  6 rst_n=0 mid-read (word 7) -> next cycle all outputs 0, banks empty; new frame outputs from word 0.

Source files
------------

// File: rtl/fft_out_stage_pp_pkg.sv
// Shared types and helpers for the ping-pong FFT output reorder stage.
package fft_out_pkg;

  localparam int unsigned MAX_AW     = 16;
  localparam int unsigned MAX_AW_IDX = $clog2(MAX_AW);

  typedef enum logic [1:0] {
    R_IDLE    = 2'd0,
    R_FETCH   = 2'd1,
    R_PRESENT = 2'd2,
    R_GAP     = 2'd3
  } rd_state_e;

  // Reverse the low 'size' bits of addr; upper bits return zero.
  function automatic logic [MAX_AW-1:0] bitrev(input logic [MAX_AW-1:0] addr,
                                               input int unsigned       size);
    logic [MAX_AW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_AW; i++) begin
      if (i < size) r[MAX_AW_IDX'(size - 1 - i)] = addr[MAX_AW_IDX'(i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_out_stage_pp_ram.sv
// Simple dual-port RAM: one write port, one read port with 1-cycle registered read.
module pp_ram #(
  parameter int unsigned DW = 48,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register doubles as the stage's output data register, so it holds unless re.
  always_ff @(posedge clk) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_out_stage_pp.sv
// Ping-pong FFT output reorder: capture a frame in one bank while the other drains
// in natural or bit-reversed order over valid/ready, with optional inter-word pacing.
module fft_out_stage_pp
  import fft_out_pkg::*;
#(
  parameter int unsigned BIT_WIDTH   = 24,
  parameter int unsigned N           = 16,
  parameter int unsigned SIZE        = 4,
  parameter int unsigned PACE_CYCLES = 5207
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        valid_i,
  input  logic signed [BIT_WIDTH-1:0] Re_i,
  input  logic signed [BIT_WIDTH-1:0] Im_i,
  input  logic [SIZE-1:0]             wr_ptr_i,
  input  logic                        bitrev_rd_i,
  input  logic                        ready_i,
  output logic signed [BIT_WIDTH-1:0] Re_o,
  output logic signed [BIT_WIDTH-1:0] Im_o,
  output logic [SIZE-1:0]             idx_o,
  output logic                        valid_o,
  output logic                        last_o,
  output logic                        done_o,
  output logic                        overflow_o
);

  localparam int unsigned DW        = 2 * BIT_WIDTH;
  localparam int unsigned LAST_IDX  = N - 1;
  localparam int unsigned PW        = (PACE_CYCLES > 1) ? $clog2(PACE_CYCLES) : 1;
  localparam int unsigned PACE_LAST = (PACE_CYCLES > 0) ? PACE_CYCLES - 1 : 0;

  rd_state_e       state_q, state_d;
  logic [SIZE-1:0] wcnt_q, rcnt_q, raddr_c;
  logic [PW-1:0]   pace_q;
  logic [1:0]      full_q, full_d;
  logic            wbank_q, rbank_q, rbitrev_q, drop_q;
  logic            start_c, re_c, accept_c, release_c;
  logic            bank_busy_c, dropping_c, wr_en_c, frame_done_c;
  logic [DW-1:0]   rdata;

  pp_ram #(.DW(DW), .AW(SIZE + 1)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en_c),
    .waddr ({wbank_q, wr_ptr_i}),
    .wdata ({Re_i, Im_i}),
    .re    (re_c),
    .raddr ({rbank_q, raddr_c}),
    .rdata (rdata)
  );

  assign Re_o = rdata[DW-1:BIT_WIDTH];
  assign Im_o = rdata[BIT_WIDTH-1:0];

  // Drop decision is made once per frame; a release in the same cycle frees the bank.
  always_comb begin
    bank_busy_c  = full_q[wbank_q] && !(release_c && (rbank_q == wbank_q));
    dropping_c   = (wcnt_q == '0) ? bank_busy_c : drop_q;
    wr_en_c      = rst_n && valid_i && !dropping_c;
    frame_done_c = wr_en_c && (wcnt_q == SIZE'(LAST_IDX));
    full_d       = full_q;
    if (release_c)    full_d[rbank_q] = 1'b0;
    if (frame_done_c) full_d[wbank_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt_q     <= '0;
      wbank_q    <= 1'b0;
      full_q     <= '0;
      drop_q     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      full_q <= full_d;
      if (valid_i) begin
        wcnt_q <= wcnt_q + SIZE'(1);
        if (wcnt_q == '0) drop_q <= dropping_c;
        if (dropping_c)   overflow_o <= 1'b1;
        if (frame_done_c) wbank_q <= ~wbank_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= R_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      R_IDLE:    if (full_q[rbank_q]) state_d = R_FETCH;
      R_FETCH:   state_d = R_PRESENT;
      R_PRESENT: begin
        if (ready_i) begin
          if (rcnt_q == SIZE'(LAST_IDX)) state_d = R_IDLE;
          else if (PACE_CYCLES > 0)      state_d = R_GAP;
          else                           state_d = R_FETCH;
        end
      end
      R_GAP:     if (pace_q == PW'(PACE_LAST)) state_d = R_PRESENT;
      default:   state_d = R_IDLE;
    endcase
  end

  // The last gap cycle also issues the fetch so the sink sees exactly PACE_CYCLES idle cycles.
  always_comb begin
    start_c   = 1'b0;
    re_c      = 1'b0;
    accept_c  = 1'b0;
    release_c = 1'b0;
    raddr_c   = rbitrev_q ? SIZE'(bitrev(MAX_AW'(rcnt_q), SIZE)) : rcnt_q;
    unique case (state_q)
      R_IDLE:    start_c = full_q[rbank_q];
      R_FETCH:   re_c = 1'b1;
      R_PRESENT: begin
        accept_c  = ready_i;
        release_c = ready_i && (rcnt_q == SIZE'(LAST_IDX));
      end
      R_GAP:     re_c = (pace_q == PW'(PACE_LAST));
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rbank_q   <= 1'b0;
      rbitrev_q <= 1'b0;
      rcnt_q    <= '0;
      pace_q    <= '0;
      idx_o     <= '0;
      valid_o   <= 1'b0;
      last_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      done_o <= release_c;
      pace_q <= (state_q == R_GAP) ? pace_q + PW'(1) : '0;
      if (start_c) begin
        rcnt_q    <= '0;
        rbitrev_q <= bitrev_rd_i;
      end
      if (re_c) begin
        idx_o   <= raddr_c;
        valid_o <= 1'b1;
        last_o  <= (rcnt_q == SIZE'(LAST_IDX));
      end
      if (accept_c) begin
        valid_o <= 1'b0;
        last_o  <= 1'b0;
        if (release_c) rbank_q <= ~rbank_q;
        else           rcnt_q  <= rcnt_q + SIZE'(1);
      end
    end
  end

endmodule

// File: tb/tb_fft_out_stage_pp.sv
// Directed bench for fft_out_stage_pp: one unpaced instance and one with PACE_CYCLES=4.
module tb_fft_out_stage_pp;

  localparam int unsigned BW = 24;
  localparam int unsigned NP = 16;
  localparam int unsigned SZ = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n, valid_i, bitrev_rd_i, ready_i;
  logic signed [BW-1:0] re_i, im_i;
  logic [SZ-1:0]        wr_ptr_i;

  logic signed [BW-1:0] re_o, im_o, re_p, im_p;
  logic [SZ-1:0]        idx_o, idx_p;
  logic                 valid_o, last_o, done_o, ovf_o;
  logic                 valid_p, last_p, done_p, ovf_p;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fft_out_stage_pp #(.BIT_WIDTH(BW), .N(NP), .SIZE(SZ), .PACE_CYCLES(0)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .Re_i(re_i), .Im_i(im_i),
    .wr_ptr_i(wr_ptr_i), .bitrev_rd_i(bitrev_rd_i), .ready_i(ready_i),
    .Re_o(re_o), .Im_o(im_o), .idx_o(idx_o), .valid_o(valid_o), .last_o(last_o),
    .done_o(done_o), .overflow_o(ovf_o)
  );

  fft_out_stage_pp #(.BIT_WIDTH(BW), .N(NP), .SIZE(SZ), .PACE_CYCLES(4)) dut_p (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .Re_i(re_i), .Im_i(im_i),
    .wr_ptr_i(wr_ptr_i), .bitrev_rd_i(bitrev_rd_i), .ready_i(ready_i),
    .Re_o(re_p), .Im_o(im_p), .idx_o(idx_p), .valid_o(valid_p), .last_o(last_p),
    .done_o(done_p), .overflow_o(ovf_p)
  );

  function automatic logic [SZ-1:0] br(input logic [SZ-1:0] a);
    return {a[0], a[1], a[2], a[3]};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1; bitrev_rd_i = 1'b0;
    re_i = '0; im_i = '0; wr_ptr_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Writes one frame of Re=base+k, Im=-(base+k) at ptr k (or bitrev(k) when scatter).
  task automatic write_frame(input int base, input bit scatter);
    for (int k = 0; k < NP; k++) begin
      valid_i  = 1'b1;
      wr_ptr_i = scatter ? br(SZ'(k)) : SZ'(k);
      re_i     = BW'(base + k);
      im_i     = -BW'(base + k);
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({valid_o, last_o, done_o, ovf_o} !== 4'b0 || re_o !== '0 || im_o !== '0 || idx_o !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got v%b l%b d%b o%b re=%0d im=%0d idx=%0d want all 0",
               valid_o, last_o, done_o, ovf_o, re_o, im_o, idx_o);
    end
    checks++;
    if ({valid_p, last_p, done_p, ovf_p} !== 4'b0 || re_p !== '0 || idx_p !== '0) begin
      failures++;
      $display("FAIL reset_outputs_paced: got v%b l%b d%b o%b re=%0d idx=%0d want all 0",
               valid_p, last_p, done_p, ovf_p, re_p, idx_p);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (valid_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_banks_empty: valid_o=%b want 0", valid_o);
    end
  endtask

  // Scattered writes, natural read: position p holds the value written at k=bitrev(p).
  task automatic test_natural();
    int n, done_seen;
    logic [BW-1:0] e;
    do_reset();
    write_frame(0, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (valid_o !== 1'b0) begin failures++; $display("FAIL latency_early: valid_o=%b want 0", valid_o); end
    @(posedge clk); #1;
    checks++;
    if (valid_o !== 1'b1) begin failures++; $display("FAIL latency: valid_o=%b want 1", valid_o); end
    done_seen = 0;
    for (int p = 0; p < NP; p++) begin
      n = 0;
      while (valid_o !== 1'b1 && n < 8) begin @(posedge clk); #1; n++; end
      e = BW'(br(SZ'(p)));
      checks++;
      if (valid_o !== 1'b1 || re_o !== e || im_o !== -e || idx_o !== SZ'(p) || last_o !== (p == NP - 1)) begin
        failures++;
        $display("FAIL natural_word%0d: got v%b re=%0d im=%0d idx=%0d last=%b want v1 re=%0d im=%0d idx=%0d last=%b",
                 p, valid_o, re_o, im_o, idx_o, last_o, e, -e, p, (p == NP - 1));
      end
      if (p > 0) begin
        checks++;
        if (n !== 1) begin failures++; $display("FAIL throughput_word%0d: gap=%0d want 1", p, n); end
      end
      @(posedge clk); #1;
      if (done_o === 1'b1) done_seen++;
    end
    @(posedge clk); #1;
    if (done_o === 1'b1) done_seen++;
    checks++;
    if (done_seen !== 1 || valid_o !== 1'b0) begin
      failures++;
      $display("FAIL natural_done: pulses=%0d valid_o=%b want 1 pulse, valid 0", done_seen, valid_o);
    end
  endtask

  // Natural writes, bit-reversed read; bitrev_rd_i dropped mid-frame must not matter.
  task automatic test_bitrev();
    int n;
    logic [BW-1:0] e;
    do_reset();
    bitrev_rd_i = 1'b1;
    write_frame(0, 1'b0);
    for (int p = 0; p < NP; p++) begin
      n = 0;
      while (valid_o !== 1'b1 && n < 8) begin @(posedge clk); #1; n++; end
      bitrev_rd_i = 1'b0;
      e = BW'(br(SZ'(p)));
      checks++;
      if (valid_o !== 1'b1 || re_o !== e || im_o !== -e || idx_o !== br(SZ'(p))) begin
        failures++;
        $display("FAIL bitrev_word%0d: got v%b re=%0d im=%0d idx=%0d want v1 re=%0d im=%0d idx=%0d",
                 p, valid_o, re_o, im_o, idx_o, e, -e, br(SZ'(p)));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int n, bad;
    do_reset();
    write_frame(0, 1'b0);
    for (int p = 0; p < NP; p++) begin
      n = 0;
      while (valid_o !== 1'b1 && n < 8) begin @(posedge clk); #1; n++; end
      checks++;
      if (valid_o !== 1'b1 || re_o !== BW'(p) || im_o !== -BW'(p) || idx_o !== SZ'(p)) begin
        failures++;
        $display("FAIL stall_word%0d: got v%b re=%0d im=%0d idx=%0d want v1 re=%0d idx=%0d",
                 p, valid_o, re_o, im_o, idx_o, p, p);
      end
      if (p == 5) begin
        ready_i = 1'b0;
        bad = 0;
        repeat (10) begin
          @(posedge clk); #1;
          if (valid_o !== 1'b1 || re_o !== BW'(5) || im_o !== -BW'(5) || idx_o !== SZ'(5)) bad++;
        end
        checks++;
        if (bad !== 0) begin
          failures++;
          $display("FAIL stall_hold: %0d unstable cycles, last v%b re=%0d idx=%0d want v1 re=5 idx=5",
                   bad, valid_o, re_o, idx_o);
        end
        ready_i = 1'b1;
      end
      @(posedge clk); #1;
    end
  endtask

  // Two frames fill both banks, the third is dropped; drained frames come out intact.
  task automatic test_overflow();
    int n, seen;
    do_reset();
    ready_i = 1'b0;
    write_frame(16, 1'b0);
    write_frame(32, 1'b0);
    checks++;
    if (ovf_o !== 1'b0) begin failures++; $display("FAIL overflow_early: overflow_o=%b want 0", ovf_o); end
    write_frame(48, 1'b0);
    checks++;
    if (ovf_o !== 1'b1 || valid_o !== 1'b1 || re_o !== BW'(16)) begin
      failures++;
      $display("FAIL overflow_set: ovf=%b valid=%b re=%0d want ovf 1 valid 1 re=16", ovf_o, valid_o, re_o);
    end
    ready_i = 1'b1;
    for (int q = 0; q < 2 * NP; q++) begin
      n = 0;
      while (valid_o !== 1'b1 && n < 8) begin @(posedge clk); #1; n++; end
      checks++;
      if (valid_o !== 1'b1 || re_o !== BW'(16 + q) || idx_o !== SZ'(q % NP) || last_o !== ((q % NP) == NP - 1)) begin
        failures++;
        $display("FAIL drain_word%0d: got v%b re=%0d idx=%0d last=%b want v1 re=%0d idx=%0d",
                 q, valid_o, re_o, idx_o, last_o, 16 + q, q % NP);
      end
      @(posedge clk); #1;
    end
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (valid_o === 1'b1) seen++; end
    checks++;
    if (seen !== 0 || ovf_o !== 1'b1) begin
      failures++;
      $display("FAIL dropped_frame: valid cycles=%0d ovf=%b want 0 and 1", seen, ovf_o);
    end
  endtask

  task automatic test_pacing();
    int n, t0;
    do_reset();
    write_frame(0, 1'b0);
    n = 0;
    while (valid_p !== 1'b1 && n < 8) begin @(posedge clk); #1; n++; end
    t0 = cyc;
    for (int p = 0; p < NP; p++) begin
      n = 0;
      while (valid_p !== 1'b1 && n < 12) begin @(posedge clk); #1; n++; end
      checks++;
      if (valid_p !== 1'b1 || re_p !== BW'(p) || idx_p !== SZ'(p) || last_p !== (p == NP - 1)) begin
        failures++;
        $display("FAIL paced_word%0d: got v%b re=%0d idx=%0d last=%b want v1 re=%0d idx=%0d",
                 p, valid_p, re_p, idx_p, last_p, p, p);
      end
      if (p > 0) begin
        checks++;
        if (n !== 4) begin failures++; $display("FAIL paced_gap%0d: idle=%0d want 4", p, n); end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (done_p !== 1'b1 || (cyc - t0) !== 76) begin
      failures++;
      $display("FAIL paced_frame_cycles: done=%b cycles=%0d want 1 and 76", done_p, cyc - t0);
    end
  endtask

  task automatic test_midread_reset();
    int n;
    do_reset();
    write_frame(0, 1'b0);
    n = 0;
    while (!(valid_o === 1'b1 && idx_o === SZ'(7)) && n < 40) begin @(posedge clk); #1; n++; end
    checks++;
    if (valid_o !== 1'b1 || idx_o !== SZ'(7)) begin
      failures++;
      $display("FAIL midread_reach: valid=%b idx=%0d want 1 and 7", valid_o, idx_o);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({valid_o, last_o, done_o, ovf_o} !== 4'b0 || re_o !== '0 || im_o !== '0 || idx_o !== '0) begin
      failures++;
      $display("FAIL midread_reset: got v%b l%b d%b o%b re=%0d im=%0d idx=%0d want all 0",
               valid_o, last_o, done_o, ovf_o, re_o, im_o, idx_o);
    end
    rst_n = 1'b1;
    n = 0;
    repeat (4) begin @(posedge clk); #1; if (valid_o === 1'b1) n++; end
    checks++;
    if (n !== 0) begin failures++; $display("FAIL midread_banks_empty: valid cycles=%0d want 0", n); end
    write_frame(100, 1'b0);
    for (int p = 0; p < NP; p++) begin
      n = 0;
      while (valid_o !== 1'b1 && n < 8) begin @(posedge clk); #1; n++; end
      checks++;
      if (valid_o !== 1'b1 || re_o !== BW'(100 + p) || idx_o !== SZ'(p)) begin
        failures++;
        $display("FAIL after_reset_word%0d: got v%b re=%0d idx=%0d want v1 re=%0d idx=%0d",
                 p, valid_o, re_o, idx_o, 100 + p, p);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_natural();
    test_bitrev();
    test_backpressure();
    test_overflow();
    test_pacing();
    test_midread_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
